// File: rtl/laser_emitter.sv
// Tripwire laser driver: warm-up, then ON/OFF phases with a detector sample at each phase end.
// All outputs registered (one edge after the deciding sample); no backpressure, arm=0 clears everything.
module laser_emitter #(
  parameter int unsigned WARMUP_CYCLES = 5000000,
  parameter int unsigned ON_CYCLES     = 50000,
  parameter int unsigned OFF_CYCLES    = 50000,
  parameter int unsigned TRIP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       beam_seen,
  output logic       laser_en,
  output logic       armed,
  output logic       tripped,
  output logic       fault,
  output logic       sample_strobe,
  output logic [3:0] miss_count
);

  localparam int unsigned MAX_WO  = (WARMUP_CYCLES > ON_CYCLES) ? WARMUP_CYCLES : ON_CYCLES;
  localparam int unsigned MAX_LEN = (MAX_WO > OFF_CYCLES) ? MAX_WO : OFF_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_ON,
    S_OFF,
    S_TRIPPED,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    miss_q, miss_d;
  logic [3:0]    miss_inc;
  logic          laser_en_q, laser_en_d;
  logic          armed_q, armed_d;
  logic          tripped_q, tripped_d;
  logic          fault_q, fault_d;
  logic          strobe_q, strobe_d;

  assign miss_inc = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    miss_d   = miss_q;
    strobe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (arm) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        if (cnt_q == CW'(WARMUP_CYCLES - 1)) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == CW'(ON_CYCLES - 1)) begin
          strobe_d = 1'b1;
          cnt_d    = '0;
          if (beam_seen) begin
            miss_d  = 4'd0;
            state_d = S_OFF;
          end else begin
            miss_d  = miss_inc;
            state_d = (miss_inc == 4'(TRIP_COUNT)) ? S_TRIPPED : S_OFF;
          end
        end
      end
      S_OFF: begin
        if (cnt_q == CW'(OFF_CYCLES - 1)) begin
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = beam_seen ? S_FAULT : S_ON;
        end
      end
      S_TRIPPED, S_FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disarm wins over any sample decided on the same edge.
    if (!arm) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      miss_d   = 4'd0;
      strobe_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    laser_en_d = (state_d == S_WARMUP) || (state_d == S_ON) || (state_d == S_TRIPPED);
    armed_d    = (state_d != S_IDLE);
    tripped_d  = (state_d == S_TRIPPED);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      miss_q     <= 4'd0;
      laser_en_q <= 1'b0;
      armed_q    <= 1'b0;
      tripped_q  <= 1'b0;
      fault_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      laser_en_q <= laser_en_d;
      armed_q    <= armed_d;
      tripped_q  <= tripped_d;
      fault_q    <= fault_d;
      strobe_q   <= strobe_d;
    end
  end

  assign laser_en      = laser_en_q;
  assign armed         = armed_q;
  assign tripped       = tripped_q;
  assign fault         = fault_q;
  assign sample_strobe = strobe_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_laser_emitter.sv
// Bench for laser_emitter: elapsed-time reference model checked every cycle, plus literal pins.
module tb_laser_emitter;

  localparam int W    = 8;
  localparam int ONC  = 4;
  localparam int OFFC = 4;
  localparam int TRIP = 2;
  localparam int PER  = ONC + OFFC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       beam_seen = 1'b0;
  logic       laser_en, armed, tripped, fault, sample_strobe;
  logic [3:0] miss_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 running, 2 tripped, 3 fault; m_t = cycles since the arming edge.
  int m_mode = 0;
  int m_t    = 0;
  int m_miss = 0;
  int m_k    = 0;
  bit m_strobe = 1'b0;

  laser_emitter #(
    .WARMUP_CYCLES(W),
    .ON_CYCLES(ONC),
    .OFF_CYCLES(OFFC),
    .TRIP_COUNT(TRIP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arm(arm),
    .beam_seen(beam_seen),
    .laser_en(laser_en),
    .armed(armed),
    .tripped(tripped),
    .fault(fault),
    .sample_strobe(sample_strobe),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic bit exp_laser();
    if (m_mode == 2) return 1'b1;
    if (m_mode != 1) return 1'b0;
    if (m_t < W) return 1'b1;
    return ((m_t - W) % PER) < ONC;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || !arm) begin
      m_mode = 0; m_t = 0; m_miss = 0; m_strobe = 1'b0;
    end else begin
      m_strobe = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
        m_t    = 0;
      end else if (m_mode == 1) begin
        if (m_t >= W) begin
          m_k = (m_t - W) % PER;
          if (m_k == ONC - 1) begin
            m_strobe = 1'b1;
            if (beam_seen) m_miss = 0;
            else begin
              m_miss = (m_miss >= 15) ? 15 : m_miss + 1;
              if (m_miss == TRIP) m_mode = 2;
            end
          end else if (m_k == PER - 1) begin
            m_strobe = 1'b1;
            if (beam_seen) m_mode = 3;
          end
        end
        m_t = m_t + 1;
      end
    end
  end

  task automatic pin(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      pin("model.laser_en", laser_en, exp_laser());
      pin("model.armed", armed, m_mode != 0);
      pin("model.tripped", tripped, m_mode == 2);
      pin("model.fault", fault, m_mode == 3);
      pin("model.sample_strobe", sample_strobe, m_strobe);
      pin("model.miss_count", miss_count, m_miss);
    end
  end

  // bm: 0/1 constant beam, 2 beam follows the laser, 3 follows the laser with random glitches.
  task automatic step(input logic a, input int bm);
    @(posedge clk);
    #2;
    arm = a;
    case (bm)
      0: beam_seen = 1'b0;
      1: beam_seen = 1'b1;
      2: beam_seen = exp_laser();
      default: beam_seen = exp_laser() ^ ($urandom_range(0, 9) == 0);
    endcase
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    pin("reset.laser_en", laser_en, 0);
    pin("reset.armed", armed, 0);
    pin("reset.tripped", tripped, 0);
    pin("reset.fault", fault, 0);
    pin("reset.strobe", sample_strobe, 0);
    pin("reset.miss", miss_count, 0);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Normal run with the beam following the laser.
    step(1, 2);
    for (int i = 0; i < 28; i++) begin
      step(1, 2);
      @(negedge clk);
      if (i == 0)  pin("t1.armed_c0", armed, 1);
      if (i == 11) pin("t1.laser_c11", laser_en, 1);
      if (i == 11) pin("t1.strobe_c11", sample_strobe, 0);
      if (i == 12) pin("t1.laser_c12", laser_en, 0);
      if (i == 12) pin("t1.strobe_c12", sample_strobe, 1);
      if (i == 16) pin("t1.laser_c16", laser_en, 1);
      if (i == 17) pin("t1.strobe_c17", sample_strobe, 0);
      if (i == 27) pin("t1.miss_c27", miss_count, 0);
    end

    // Two consecutive misses trip the wire.
    step(0, 0); step(1, 0);
    for (int i = 0; i < 26; i++) begin
      step(1, 0);
      @(negedge clk);
      if (i == 12) pin("t2.miss_c12", miss_count, 1);
      if (i == 16) pin("t2.laser_c16", laser_en, 1);
      if (i == 20) pin("t2.tripped_c20", tripped, 1);
      if (i == 20) pin("t2.miss_c20", miss_count, 2);
      if (i == 20) pin("t2.strobe_c20", sample_strobe, 1);
      if (i == 25) pin("t2.strobe_c25", sample_strobe, 0);
      if (i == 25) pin("t2.laser_c25", laser_en, 1);
    end

    // One miss then a hit clears the count.
    step(0, 0); step(1, 2);
    for (int i = 0; i < 24; i++) begin
      step(1, (i >= 8 && i <= 11) ? 0 : 2);
      @(negedge clk);
      if (i == 12) pin("t3.miss_c12", miss_count, 1);
      if (i == 20) pin("t3.miss_c20", miss_count, 0);
      if (i == 20) pin("t3.tripped_c20", tripped, 0);
      if (i == 20) pin("t3.strobe_c20", sample_strobe, 1);
    end

    // Beam seen at the end of an OFF phase latches a fault.
    step(0, 0); step(1, 2);
    for (int i = 0; i < 22; i++) begin
      step(1, (i >= 12 && i <= 15) ? 1 : 2);
      @(negedge clk);
      if (i == 16) pin("t4.fault_c16", fault, 1);
      if (i == 16) pin("t4.laser_c16", laser_en, 0);
      if (i == 16) pin("t4.tripped_c16", tripped, 0);
      if (i == 21) pin("t4.fault_c21", fault, 1);
      if (i == 21) pin("t4.strobe_c21", sample_strobe, 0);
    end
    step(0, 0); step(0, 0);
    @(negedge clk);
    pin("t4.clr_fault", fault, 0);
    pin("t4.clr_armed", armed, 0);
    pin("t4.clr_laser", laser_en, 0);

    // Disarm on the edge that would take the second miss.
    step(1, 0);
    for (int i = 0; i < 21; i++) begin
      step((i >= 19) ? 1'b0 : 1'b1, 0);
      @(negedge clk);
      if (i == 19) pin("t5.miss_c19", miss_count, 1);
      if (i == 20) pin("t5.tripped_c20", tripped, 0);
      if (i == 20) pin("t5.miss_c20", miss_count, 0);
      if (i == 20) pin("t5.armed_c20", armed, 0);
    end
    step(1, 0);
    for (int j = 0; j < 13; j++) begin
      step(1, 2);
      @(negedge clk);
      if (j == 8)  pin("t5.strobe_c8", sample_strobe, 0);
      if (j == 11) pin("t5.strobe_c11", sample_strobe, 0);
      if (j == 12) pin("t5.strobe_c12", sample_strobe, 1);
    end

    // Asynchronous reset in the middle of warm-up.
    step(0, 0); step(1, 2);
    for (int j = 0; j < 4; j++) begin
      step(1, 2);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    pin("t6.async_laser", laser_en, 0);
    pin("t6.async_armed", armed, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    arm = 1'b1;
    beam_seen = 1'b0;
    for (int j = 0; j < 21; j++) begin
      step(1, 2);
      @(negedge clk);
      if (j == 11) pin("t6.laser_c11", laser_en, 1);
      if (j == 12) pin("t6.laser_c12", laser_en, 0);
      if (j == 12) pin("t6.strobe_c12", sample_strobe, 1);
    end

    // Random arm drops and beam glitches against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 59) != 0, 3);
    end
    step(0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_emitter.md
Name: laser_emitter

Overview:
- Drives the tripwire laser diode: arms, warms up, then pulses the beam with a fixed ON/OFF pattern.
- Samples the detector's beam-present flag at the end of every phase.
- ON phase with no beam for TRIP_COUNT consecutive samples: the wire is crossed, so the block latches a trip.
- OFF phase with beam seen: ambient light or tamper, so the block latches a fault.
- Sits between the game/alarm controller (arm) and the light-sensor detector (beam_seen).

Parameters:
- WARMUP_CYCLES, 5000000, cycles the laser is held on before the first sample (100 ms at 50 MHz); must be ≥1.
- ON_CYCLES, 50000, length of each ON phase in cycles; must be ≥2.
- OFF_CYCLES, 50000, length of each OFF phase in cycles; must be ≥2.
- TRIP_COUNT, 3, consecutive missed ON samples that latch a trip; range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  level; 1 = run, 0 = disarm and clear all latches.
- beam_seen  input  1  from detector; 1 = sensor currently sees the laser; synchronous to clk.
- laser_en  output  1  laser diode drive, registered.
- armed  output  1  1 in any state other than IDLE.
- tripped  output  1  latched beam-crossed alarm.
- fault  output  1  latched beam-seen-while-off alarm.
- sample_strobe  output  1  1-cycle pulse marking that a sample was taken.
- miss_count  output  4  current consecutive-miss count.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous): state=IDLE, phase counter=0, miss_count=0, laser_en=0, armed=0, tripped=0, fault=0, sample_strobe=0.
- Phase counter width is $clog2(max(WARMUP_CYCLES,ON_CYCLES,OFF_CYCLES)+1). It counts 0..LEN-1 and resets to 0 on every state change.
- States: IDLE, WARMUP, ON, OFF, TRIPPED, FAULT.
- Priority: arm=0 at a clock edge overrides every other transition. The next state is IDLE, with counter=0, miss_count=0, tripped=0, fault=0, laser_en=0.
- IDLE: laser_en=0. arm=1 sampled at edge N moves to WARMUP, and laser_en=1 from edge N.
- WARMUP: laser_en=1 for exactly WARMUP_CYCLES cycles, then ON. No sampling and no trip checks during WARMUP.
- ON: laser_en=1 for ON_CYCLES cycles. At the edge ending the last cycle (counter=ON_CYCLES-1), beam_seen is sampled:
  - beam_seen=1: miss_count←0; next state OFF.
  - beam_seen=0: miss_count←miss_count+1, saturating at 15.
  - If the incremented value equals TRIP_COUNT: tripped←1 and next state TRIPPED. Otherwise next state OFF.
- OFF: laser_en=0 for OFF_CYCLES cycles. At the edge ending the last cycle, beam_seen is sampled:
  - beam_seen=1: fault←1; next state FAULT.
  - beam_seen=0: next state ON. miss_count is unchanged.
- sample_strobe=1 for exactly the one cycle following each sampling edge (ON or OFF), including the sample that causes a trip or fault. It is 0 otherwise.
- TRIPPED: laser_en=1 (beam stays on for the visual cue), tripped=1, and no further sampling. Exit only via arm=0.
- FAULT: laser_en=0, fault=1, and no further sampling. Exit only via arm=0.
- tripped and fault are never both 1.
- Re-arming (arm 0 to 1) always restarts from WARMUP with the full warm-up time.
- beam_seen is ignored on every cycle except sampling edges; glitches mid-phase have no effect.
- Reset mid-phase aborts immediately. laser_en drops asynchronously with rst_n.

Test Plan:
Bench parameters for every scenario: WARMUP_CYCLES=8, ON_CYCLES=4, OFF_CYCLES=4, TRIP_COUNT=2.
1. Reset, then arm=1, beam_seen tracks laser_en → laser_en high for 12 cycles, then 4 low / 4 high repeating. sample_strobe every 4 cycles. tripped=fault=0, miss_count=0 throughout.
2. Armed and running. Force beam_seen=0 for two consecutive ON samples → miss_count goes 1 then 2. tripped=1 one edge after the second sample, state TRIPPED, laser_en held 1, sample_strobe stops after that pulse.
3. One missed ON sample, then the next ON sample sees beam → miss_count 1 then 0. No trip.
4. beam_seen=1 at the end of an OFF phase → fault=1, laser_en=0, tripped=0. Held until arm=0, after which all outputs are 0 the next cycle.
5. arm drops mid-ON-phase on the same edge that would sample a second miss → IDLE, tripped stays 0, miss_count=0. Re-arm gives a full 8-cycle warm-up before the first ON sample.
6. Assert rst_n=0 asynchronously mid-WARMUP (between edges) → laser_en=0 and armed=0 immediately. After release with arm=1, the full sequence restarts.
